// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types and defaults for the 3-to-8 decoder pipeline
package dec_pkg;

  localparam int CODE_W_DEF = 3;
  localparam int N_DEF      = 1 << CODE_W_DEF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [N_DEF-1:0] onehot;
    logic             zero;
  } entry_t;

endpackage

// File: rtl/dec_skid_buf.sv
// rtl/dec_skid_buf.sv - two-entry in-order buffer with registered-only in_ready
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          in_fire;
  logic          out_fire;

  // ready/valid come straight from the state register, so out_ready never reaches in_ready
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = head_q;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  // next state: head is always the oldest word, tail only used when FULL
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_d  = in_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_data_i;
        end else if (in_fire) begin
          tail_d  = in_data_i;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // state and storage registers; reset drops any buffered words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/dec_3x8_pipe.sv
// rtl/dec_3x8_pipe.sv - binary-to-one-hot decoder with buffered output and sticky mask
module dec_3x8_pipe
  import dec_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<CODE_W)-1:0] out_onehot,
  output logic                   out_zero,
  output logic [(1<<CODE_W)-1:0] mask,
  input  logic                   mask_clr
);

  localparam int N = 1 << CODE_W;

  logic [N-1:0] dec_onehot;
  logic         dec_zero;
  logic [N:0]   buf_out;
  logic         out_fire;
  logic [N-1:0] mask_q, mask_d;

  // decode: in_en=0 means "no bit set", flagged through zero
  always_comb begin
    dec_onehot = '0;
    if (in_en) begin
      dec_onehot[in_code] = 1'b1;
    end
    dec_zero = ~in_en;
  end

  dec_skid_buf #(
    .DW (N + 1)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({dec_onehot, dec_zero}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (buf_out)
  );

  assign out_onehot = buf_out[N:1];
  assign out_zero   = buf_out[0];
  assign out_fire   = out_valid && out_ready;
  assign mask       = mask_q;

  // mask accumulates delivered words; a clear in a delivery cycle keeps only that word
  always_comb begin
    mask_d = mask_q;
    if (mask_clr) begin
      mask_d = '0;
    end
    if (out_fire) begin
      mask_d = mask_d | out_onehot;
    end
  end

  // mask register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

endmodule

// File: tb/tb_dec_3x8_pipe.sv
// tb/tb_dec_3x8_pipe.sv - scoreboard bench for dec_3x8_pipe
module tb_dec_3x8_pipe;
  import dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic       out_zero;
  logic [7:0] mask;
  logic       mask_clr;

  int     errors    = 0;
  int     checks    = 0;
  int     delivered = 0;
  bit     mon_en    = 1'b0;
  entry_t sb[$];
  logic [7:0] mmask;
  logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  dec_3x8_pipe #(.CODE_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_zero   (out_zero),
    .mask       (mask),
    .mask_clr   (mask_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic e, input logic [7:0] exp_oh);
    int n;
    entry_t ent;
    in_valid = 1'b1;
    in_code  = c;
    in_en    = e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      tick();
      ent.onehot = exp_oh;
      ent.zero   = ~e;
      sb.push_back(ent);
    end
    in_valid = 1'b0;
  endtask

  // monitor: compares DUT outputs against the scoreboard head and occupancy every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
      chk("mask", {24'd0, mask}, {24'd0, mmask});
      if (out_valid && sb.size() > 0) begin
        chk("out_onehot", {24'd0, out_onehot}, {24'd0, sb[0].onehot});
        chk("out_zero", {31'd0, out_zero}, {31'd0, sb[0].zero});
      end
      if (!rst_n) begin
        sb.delete();
        mmask = 8'h00;
      end else begin
        if (mask_clr) mmask = 8'h00;
        if (out_valid && out_ready && sb.size() > 0) begin
          mmask = mmask | sb[0].onehot;
          void'(sb.pop_front());
          delivered++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sent;
    int n;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0;
    out_ready = 1'b0; mask_clr = 1'b0; mmask = 8'h00;
    repeat (2) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_onehot", {24'd0, out_onehot}, 32'd0);
    chk("rst_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_mask", {24'd0, mask}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // codes 0..7 back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 1'b1, tbl[i]);
    tick();
    chk("mask_all", {24'd0, mask}, 32'h0000_00FF);

    // in_en=0 word
    send(3'd6, 1'b0, 8'h00);
    chk("en0_onehot", {24'd0, out_onehot}, 32'h00);
    chk("en0_zero", {31'd0, out_zero}, 32'd1);
    repeat (2) tick();
    chk("en0_mask", {24'd0, mask}, 32'h0000_00FF);

    // fill with out_ready low, then drain in order
    out_ready = 1'b0;
    send(3'd5, 1'b1, 8'h20);
    send(3'd2, 1'b1, 8'h04);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_onehot", {24'd0, out_onehot}, 32'h20);
    repeat (3) tick();
    chk("hold_onehot", {24'd0, out_onehot}, 32'h20);
    out_ready = 1'b1;
    tick();
    chk("drain2_onehot", {24'd0, out_onehot}, 32'h04);
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // mask clear alone, then clear coinciding with a delivery
    mask_clr = 1'b1; tick(); mask_clr = 1'b0;
    chk("clr_mask", {24'd0, mask}, 32'h00);
    send(3'd0, 1'b1, 8'h01);
    send(3'd5, 1'b1, 8'h20);
    repeat (2) tick();
    chk("mask_21", {24'd0, mask}, 32'h21);
    out_ready = 1'b0;
    send(3'd3, 1'b1, 8'h08);
    chk("mask_21_hold", {24'd0, mask}, 32'h21);
    mask_clr = 1'b1; out_ready = 1'b1; tick(); mask_clr = 1'b0;
    chk("clr_with_xfer", {24'd0, mask}, 32'h08);
    mask_clr = 1'b1; tick(); mask_clr = 1'b0;
    chk("clr_alone", {24'd0, mask}, 32'h00);

    // reset while FULL, with an input offered in the reset cycle
    out_ready = 1'b0;
    send(3'd1, 1'b1, 8'h02);
    send(3'd4, 1'b1, 8'h10);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0; in_valid = 1'b1; in_code = 3'd7; in_en = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_mask", {24'd0, mask}, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (5) tick();

    // random valid/ready stream
    base = delivered;
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 20000) begin
      entry_t ent;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = 3'($urandom);
      in_en     = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mask_clr  = ($urandom_range(0, 15) == 0);
      acc = in_valid && in_ready;
      ent.onehot = in_en ? (8'h01 << in_code) : 8'h00;
      ent.zero   = ~in_en;
      tick();
      if (acc) begin
        sb.push_back(ent);
        sent++;
      end
      n++;
    end
    in_valid = 1'b0; mask_clr = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("rand_sent", sent, 1000);
    chk("rand_drained", sb.size(), 0);
    chk("rand_delivered", delivered - base, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
